dmem_arbiter: RTL and testbench

- Shares the single-port word-addressed data memory (1024 x 32, synchronous write, combinational read, RD forced 0 in reset) between the pipeline MEM stage (CPU port) and a loader/DMA port.
- Merges byte-enabled CPU stores into full-word writes: the old word is read and the new word written in the same cycle.
- Default priority goes to the CPU; a starvation counter and a bounded burst lock guarantee DMA progress.
- Stalls the pipeline whenever the DMA owns the memory.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_be_merge.sv | 17 +
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: arbiter state and owner
// encodings, memory depth, and the byte-lane merge used by store paths.
package dmem_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam int DMEM_WORDS = 1024;

  // Per-byte select: lanes with be set take new_wd, the rest keep old_wd.
  function automatic logic [31:0] be_merge(input logic [31:0] new_wd,
                                           input logic [31:0] old_wd,
                                           input logic [3:0]  be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = be[i] ? new_wd[8*i +: 8] : old_wd[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the arbiter, the CPU MEM stage, the DMA/loader port and
// the single-port data memory. The arbiter uses the slave view; the
// surrounding system (CPU, DMA, memory) uses the master view.
interface dmem_arbiter_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rd;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_we;
  logic        dma_lock;
  logic [31:0] dma_addr;
  logic [31:0] dma_wd;
  logic        dma_gnt;
  logic [31:0] dma_rd;
  logic        dma_rvalid;

  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd, cpu_be,
    output cpu_rd, cpu_stall,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wd,
    output dma_gnt, dma_rd, dma_rvalid,
    output mem_a, mem_wd, mem_we,
    input  mem_rd
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd, cpu_be,
    input  cpu_rd, cpu_stall,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wd,
    input  dma_gnt, dma_rd, dma_rvalid,
    input  mem_a, mem_wd, mem_we,
    output mem_rd
  );

endinterface

// File: rtl/dmem_be_merge.sv
// Combinational byte-lane merge: builds the full word written back for a
// byte-enabled CPU store from the store data and the word currently in memory.
module dmem_be_merge
  import dmem_pkg::*;
(
  input  logic [31:0] new_wd,
  input  logic [31:0] old_wd,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  // Read-modify-write happens in one cycle, so this is pure combinational.
  always_comb begin
    merged = be_merge(new_wd, old_wd, be);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and the DMA/loader port.
// CPU has default priority; a starvation counter forces a DMA slot, and a
// bounded burst lock lets the DMA keep the memory for up to MAX_BURST beats.
// Optional build macro: DMEM_ARB_PERF_EN adds saturating performance counters
// perf_stall_cyc and perf_dma_beats.
//
// state | meaning
// ARB   | normal arbitration, CPU wins contested cycles unless DMA is starved
// BURST | DMA holds the memory for locked continuation beats
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_BURST    = 4,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic reset,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_dma_beats
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);

  arb_state_e      state;
  logic [SW-1:0]   starve_cnt;
  logic [BW-1:0]   beat_cnt;
  logic [BW-1:0]   beat_next;
  owner_e          owner;
  logic            gnt;
  logic [31:0]     merged;

  dmem_be_merge u_merge (
    .new_wd (bus.cpu_wd),
    .old_wd (bus.mem_rd),
    .be     (bus.cpu_be),
    .merged (merged)
  );

  // Owner select: burst keeps DMA, otherwise CPU unless idle or DMA starved.
  always_comb begin
    owner = OWN_CPU;
    if (state == BURST) begin
      owner = OWN_DMA;
    end else if (bus.dma_req && (!bus.cpu_req || starve_cnt == STARVE_MAX)) begin
      owner = OWN_DMA;
    end
  end

  assign gnt           = reset && (owner == OWN_DMA) && bus.dma_req;
  assign bus.dma_gnt   = gnt;
  assign bus.cpu_stall = reset && bus.cpu_req && (owner == OWN_DMA);
  assign bus.cpu_rd    = bus.mem_rd;
  assign beat_next     = beat_cnt + BW'(1);

  // Memory port drive; writes are suppressed entirely while in reset.
  always_comb begin
    bus.mem_a  = bus.cpu_addr;
    bus.mem_wd = merged;
    bus.mem_we = 1'b0;
    if (gnt) begin
      bus.mem_a  = bus.dma_addr;
      bus.mem_wd = bus.dma_wd;
      bus.mem_we = bus.dma_we;
    end else if (reset && owner == OWN_CPU && bus.cpu_req && bus.cpu_we) begin
      bus.mem_we = |bus.cpu_be;
    end
  end

  // Arbiter FSM, starvation counter and registered DMA read return.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= ARB;
      starve_cnt     <= '0;
      beat_cnt       <= '0;
      bus.dma_rd     <= '0;
      bus.dma_rvalid <= 1'b0;
    end else begin
      if (!bus.dma_req || gnt) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + SW'(1);
      end

      bus.dma_rvalid <= gnt && !bus.dma_we;
      if (gnt && !bus.dma_we) begin
        bus.dma_rd <= bus.mem_rd;
      end

      case (state)
        ARB: begin
          if (gnt && bus.dma_lock && (BW'(1) < BURST_MAX)) begin
            state    <= BURST;
            beat_cnt <= BW'(1);
          end
        end
        BURST: begin
          // The beat that reaches MAX_BURST hands the memory back to ARB.
          if (gnt && bus.dma_lock && (beat_next < BURST_MAX)) begin
            beat_cnt <= beat_next;
          end else begin
            state    <= ARB;
            beat_cnt <= '0;
          end
        end
        default: begin
          state    <= ARB;
          beat_cnt <= '0;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // Saturating counters of stall cycles and granted DMA beats.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_stall_cyc <= '0;
      perf_dma_beats <= '0;
    end else begin
      if (bus.cpu_stall && !(&perf_stall_cyc)) begin
        perf_stall_cyc <= perf_stall_cyc + CNT_W'(1);
      end
      if (gnt && !(&perf_dma_beats)) begin
        perf_dma_beats <= perf_dma_beats + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024 x 32 memory model.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] perf_stall_cyc;
  logic [15:0] perf_dma_beats;
`endif

  dmem_arbiter #(.STARVE_LIMIT(8), .MAX_BURST(4), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_dma_beats (perf_dma_beats)
`endif
  );

  logic [31:0] mem [DMEM_WORDS];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  // Memory model: synchronous write (backdoor preload has priority).
  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (bus.mem_we) mem[bus.mem_a[11:2]] <= bus.mem_wd;
  end

  assign bus.mem_rd = reset ? mem[bus.mem_a[11:2]] : 32'h0;

  int n_vec = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wd = 0; bus.cpu_be = 0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_lock = 0; bus.dma_addr = 0; bus.dma_wd = 0;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    bd_we = 1; bd_idx = idx; bd_data = data;
    tick();
    bd_we = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h40; bus.cpu_wd = 32'hFFFF_FFFF; bus.cpu_be = 4'hF;
    bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'h40; bus.dma_wd = 32'h0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we cyc%0d: got %b want 0", i, bus.mem_we); end
      n_vec++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall cyc%0d: got %b want 0", i, bus.cpu_stall); end
      n_vec++; if (bus.dma_gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt cyc%0d: got %b want 0", i, bus.dma_gnt); end
      n_vec++; if (bus.dma_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid cyc%0d: got %b want 0", i, bus.dma_rvalid); end
      tick();
    end
    idle();
    reset = 1;
    #1;
    n_vec++; if (bus.dma_rd !== 32'h0) begin n_err++; $display("FAIL reset_dma_rd: got %h want 00000000", bus.dma_rd); end
    n_vec++; if (mem[16] !== 32'hCAFE_F00D) begin n_err++; $display("FAIL reset_mem_kept: got %h want cafef00d", mem[16]); end
    tick();
  endtask

  task automatic test_cpu_store();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h10; bus.cpu_be = 4'b0010; bus.cpu_wd = 32'h0000_AB00;
    #1;
    n_vec++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL store_stall: got %b want 0", bus.cpu_stall); end
    n_vec++; if (bus.mem_we !== 1'b1) begin n_err++; $display("FAIL store_mem_we: got %b want 1", bus.mem_we); end
    n_vec++; if (bus.mem_wd !== 32'h1122_AB44) begin n_err++; $display("FAIL store_merge: got %h want 1122ab44", bus.mem_wd); end
    tick();
    n_vec++; if (mem[4] !== 32'h1122_AB44) begin n_err++; $display("FAIL store_word4: got %h want 1122ab44", mem[4]); end
    bus.cpu_be = 4'b0000; bus.cpu_wd = 32'hFFFF_FFFF;
    #1;
    n_vec++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL store_be0_we: got %b want 0", bus.mem_we); end
    tick();
    bus.cpu_we = 0; bus.cpu_be = 4'hF;
    #1;
    n_vec++; if (bus.cpu_rd !== 32'h1122_AB44) begin n_err++; $display("FAIL load_word4: got %h want 1122ab44", bus.cpu_rd); end
    n_vec++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL load_mem_we: got %b want 0", bus.mem_we); end
    tick();
    idle();
  endtask

  task automatic test_dma_write();
    bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'h20; bus.dma_wd = 32'hDEAD_BEEF;
    #1;
    n_vec++; if (bus.dma_gnt !== 1'b1) begin n_err++; $display("FAIL dmaw_gnt: got %b want 1", bus.dma_gnt); end
    n_vec++; if (bus.mem_we !== 1'b1) begin n_err++; $display("FAIL dmaw_mem_we: got %b want 1", bus.mem_we); end
    n_vec++; if (bus.mem_a !== 32'h20) begin n_err++; $display("FAIL dmaw_mem_a: got %h want 00000020", bus.mem_a); end
    tick();
    idle();
    bus.cpu_req = 1; bus.cpu_addr = 32'h20;
    #1;
    n_vec++; if (bus.cpu_rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL dmaw_readback: got %h want deadbeef", bus.cpu_rd); end
    tick();
    idle();
  endtask

  task automatic test_starvation();
    bus.cpu_req = 1; bus.cpu_addr = 32'h10;
    bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h40;
    for (int c = 1; c <= 9; c++) begin
      logic exp_g;
      exp_g = (c == 9);
      #1;
      n_vec++; if (bus.dma_gnt !== exp_g) begin n_err++; $display("FAIL starve_gnt cyc%0d: got %b want %b", c, bus.dma_gnt, exp_g); end
      n_vec++; if (bus.cpu_stall !== exp_g) begin n_err++; $display("FAIL starve_stall cyc%0d: got %b want %b", c, bus.cpu_stall, exp_g); end
      tick();
    end
    #1;
    n_vec++; if (bus.dma_gnt !== 1'b0) begin n_err++; $display("FAIL starve_cleared: got gnt %b want 0", bus.dma_gnt); end
    n_vec++; if (bus.dma_rvalid !== 1'b1) begin n_err++; $display("FAIL starve_rvalid: got %b want 1", bus.dma_rvalid); end
    n_vec++; if (bus.dma_rd !== 32'hCAFE_F00D) begin n_err++; $display("FAIL starve_dma_rd: got %h want cafef00d", bus.dma_rd); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_burst();
    bus.cpu_req = 1; bus.cpu_addr = 32'h10;
    bus.dma_req = 1; bus.dma_we = 1; bus.dma_lock = 1; bus.dma_addr = 32'h30;
    for (int c = 1; c <= 13; c++) begin
      logic exp_g;
      exp_g = (c >= 9) && (c <= 12);
      bus.dma_wd = 32'hB000_0000 + 32'(c);
      #1;
      n_vec++; if (bus.dma_gnt !== exp_g) begin n_err++; $display("FAIL burst_gnt cyc%0d: got %b want %b", c, bus.dma_gnt, exp_g); end
      n_vec++; if (bus.cpu_stall !== exp_g) begin n_err++; $display("FAIL burst_stall cyc%0d: got %b want %b", c, bus.cpu_stall, exp_g); end
      tick();
    end
    n_vec++; if (mem[12] !== 32'hB000_000C) begin n_err++; $display("FAIL burst_last_beat: got %h want b000000c", mem[12]); end
    idle();
    tick();
  endtask

  task automatic test_dma_read();
    bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h8;
    #1;
    n_vec++; if (bus.dma_gnt !== 1'b1) begin n_err++; $display("FAIL dmar_gnt: got %b want 1", bus.dma_gnt); end
    n_vec++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL dmar_mem_we: got %b want 0", bus.mem_we); end
    tick();
    idle();
    #1;
    n_vec++; if (bus.dma_rvalid !== 1'b1) begin n_err++; $display("FAIL dmar_rvalid: got %b want 1", bus.dma_rvalid); end
    n_vec++; if (bus.dma_rd !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL dmar_data: got %h want 5a5a5a5a", bus.dma_rd); end
    tick();
    #1;
    n_vec++; if (bus.dma_rvalid !== 1'b0) begin n_err++; $display("FAIL dmar_rvalid_drop: got %b want 0", bus.dma_rvalid); end
    n_vec++; if (bus.dma_rd !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL dmar_hold: got %h want 5a5a5a5a", bus.dma_rd); end
    tick();
  endtask

  task automatic test_burst_idle();
    bus.dma_req = 1; bus.dma_we = 1; bus.dma_lock = 1; bus.dma_addr = 32'h34; bus.dma_wd = 32'h7777_7777;
    #1;
    n_vec++; if (bus.dma_gnt !== 1'b1) begin n_err++; $display("FAIL bidle_first_gnt: got %b want 1", bus.dma_gnt); end
    tick();
    idle();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h34; bus.cpu_be = 4'hF; bus.cpu_wd = 32'h1234_5678;
    #1;
    n_vec++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL bidle_no_access: got mem_we %b want 0", bus.mem_we); end
    n_vec++; if (bus.cpu_stall !== 1'b1) begin n_err++; $display("FAIL bidle_stall: got %b want 1", bus.cpu_stall); end
    n_vec++; if (bus.dma_gnt !== 1'b0) begin n_err++; $display("FAIL bidle_gnt: got %b want 0", bus.dma_gnt); end
    tick();
    #1;
    n_vec++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL bidle_back_arb: got stall %b want 0", bus.cpu_stall); end
    tick();
    idle();
    n_vec++; if (mem[13] !== 32'h1234_5678) begin n_err++; $display("FAIL bidle_cpu_write: got %h want 12345678", mem[13]); end
  endtask

  task automatic test_reset_mid_burst();
    bus.dma_req = 1; bus.dma_we = 1; bus.dma_lock = 1; bus.dma_addr = 32'h38; bus.dma_wd = 32'h1111_1111;
    #1;
    n_vec++; if (bus.dma_gnt !== 1'b1) begin n_err++; $display("FAIL mrst_first_gnt: got %b want 1", bus.dma_gnt); end
    tick();
    reset = 0;
    bus.dma_wd = 32'h2222_2222; bus.cpu_req = 1;
    #1;
    n_vec++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL mrst_mem_we: got %b want 0", bus.mem_we); end
    n_vec++; if (bus.dma_gnt !== 1'b0) begin n_err++; $display("FAIL mrst_gnt: got %b want 0", bus.dma_gnt); end
    n_vec++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL mrst_stall: got %b want 0", bus.cpu_stall); end
    tick();
    reset = 1;
    #1;
    n_vec++; if (bus.dma_gnt !== 1'b0) begin n_err++; $display("FAIL mrst_burst_aborted: got gnt %b want 0", bus.dma_gnt); end
    tick();
    idle();
    n_vec++; if (mem[14] !== 32'h1111_1111) begin n_err++; $display("FAIL mrst_mem14: got %h want 11111111", mem[14]); end
  endtask

  initial begin
    idle();
    reset = 0;
    tick();
    preload(10'd16, 32'hCAFE_F00D);
    preload(10'd4,  32'h1122_3344);
    preload(10'd2,  32'h5A5A_5A5A);
    test_reset();
    test_cpu_store();
    test_dma_write();
    test_starvation();
    test_burst();
    test_dma_read();
    test_burst_idle();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
